uart_frame_decoder: RTL and testbench

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_decoder.sv | 189 ++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: collects UART bytes between rts falling and rising edges
// into a command frame, validates it and replays it as LED memory writes.
// Optional feature: define UART_FRAME_CHECKSUM_EN to require a trailing XOR
// checksum byte on every frame.
module uart_frame_decoder #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_BYTES    = 3
) (
  input  logic                     clock_12mhz,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_ready,
  input  logic                     rts,
  input  logic                     write_ready,
  output logic                     perform_write,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [8*DATA_BYTES-1:0]  write_data,
  output logic                     busy,
  output logic                     frame_error
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CHECK_BYTES = 1;
`else
  localparam int CHECK_BYTES = 0;
`endif

  localparam logic [7:0] CMD_SET_LED   = 8'h01;
  localparam logic [7:0] CMD_SET_RANGE = 8'h02;
  localparam int         LED_LEN       = 3 + DATA_BYTES + CHECK_BYTES;
  localparam int         RANGE_LEN     = 4 + DATA_BYTES + CHECK_BYTES;
  // One past the longest legal frame: any longer frame parks here and stays invalid.
  localparam logic [3:0] COUNT_SAT     = 4'(RANGE_LEN + 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, EXECUTE} state_t;

  state_t                   state_reg, state_next;
  logic                     rts_meta_reg, rts_sync_reg, rts_prev_reg;
  logic                     rts_fall, rts_rise;
  logic [3:0]               count_reg, count_eff;
  logic [7:0]               frame_reg [0:15];
  logic [7:0]               cmd_eff;
  logic                     frame_valid;
  logic                     error_next;
  logic                     perform_write_reg;
  logic                     frame_error_reg;
  logic [ADDRESS_WIDTH-1:0] write_address_reg;
  logic [8*DATA_BYTES-1:0]  write_data_reg;
  logic [8*DATA_BYTES-1:0]  payload;
  logic [8:0]               remaining_reg;
  logic [3:0]               payload_offset;
  logic                     checksum_ok;

  assign rts_fall = rts_prev_reg & ~rts_sync_reg;
  assign rts_rise = ~rts_prev_reg & rts_sync_reg;

  // A byte strobed in the same cycle as the closing edge still counts toward the frame.
  assign count_eff = (rx_data_ready && count_reg != COUNT_SAT) ? count_reg + 4'd1 : count_reg;
  assign cmd_eff   = (count_reg == 4'd0) ? rx_data : frame_reg[0];

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] xor_reg, xor_eff;
  // Running XOR of the whole frame including the checksum byte must end at zero.
  assign xor_eff     = rx_data_ready ? (xor_reg ^ rx_data) : xor_reg;
  assign checksum_ok = (xor_eff == 8'd0);

  // Checksum accumulator, cleared when a new frame opens.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset)
      xor_reg <= 8'd0;
    else if (state_reg == IDLE && rts_fall)
      xor_reg <= 8'd0;
    else if (state_reg == RECEIVE && rx_data_ready)
      xor_reg <= xor_eff;
  end
`else
  assign checksum_ok = 1'b1;
`endif

  assign frame_valid = checksum_ok &&
                       ((cmd_eff == CMD_SET_LED   && count_eff == 4'(LED_LEN)) ||
                        (cmd_eff == CMD_SET_RANGE && count_eff == 4'(RANGE_LEN)));

  // Payload position depends on whether a count byte precedes it; bytes are big-endian.
  assign payload_offset = (frame_reg[0] == CMD_SET_RANGE) ? 4'd4 : 4'd3;
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_payload
    assign payload[8*(DATA_BYTES-1-gi) +: 8] = frame_reg[payload_offset + 4'(gi)];
  end

  // rts two-flop synchroniser plus a history flop for edge detection; idles high.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      rts_meta_reg <= 1'b1;
      rts_sync_reg <= 1'b1;
      rts_prev_reg <= 1'b1;
    end else begin
      rts_meta_reg <= rts;
      rts_sync_reg <= rts_meta_reg;
      rts_prev_reg <= rts_sync_reg;
    end
  end

  // FSM state register.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state and error-pulse decode; rts edges are ignored outside IDLE/RECEIVE.
  always_comb begin
    state_next = state_reg;
    error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_data_ready) error_next = 1'b1;
        if (rts_fall) state_next = RECEIVE;
      end
      RECEIVE: begin
        if (rts_rise) begin
          if (frame_valid) begin
            state_next = EXECUTE;
          end else begin
            state_next = IDLE;
            error_next = 1'b1;
          end
        end
      end
      EXECUTE: begin
        if (rx_data_ready) error_next = 1'b1;
        if (perform_write_reg && write_ready && remaining_reg == 9'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame capture in RECEIVE and write sequencing in EXECUTE.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      count_reg         <= 4'd0;
      remaining_reg     <= 9'd0;
      perform_write_reg <= 1'b0;
      frame_error_reg   <= 1'b0;
      write_address_reg <= '0;
      write_data_reg    <= '0;
      for (int i = 0; i < 16; i++) frame_reg[i] <= 8'd0;
    end else begin
      frame_error_reg <= error_next;
      case (state_reg)
        IDLE: begin
          if (rts_fall) count_reg <= 4'd0;
        end
        RECEIVE: begin
          if (rx_data_ready) begin
            count_reg <= count_eff;
            if (count_reg < 4'(RANGE_LEN)) frame_reg[count_reg] <= rx_data;
          end
        end
        EXECUTE: begin
          if (!perform_write_reg) begin
            perform_write_reg <= 1'b1;
            write_address_reg <= ADDRESS_WIDTH'({frame_reg[1], frame_reg[2]});
            write_data_reg    <= payload;
            if (frame_reg[0] == CMD_SET_RANGE)
              remaining_reg <= (frame_reg[3] == 8'd0) ? 9'd256 : {1'b0, frame_reg[3]};
            else
              remaining_reg <= 9'd1;
          end else if (write_ready) begin
            if (remaining_reg == 9'd1) begin
              perform_write_reg <= 1'b0;
            end else begin
              write_address_reg <= write_address_reg + ADDRESS_WIDTH'(1);
              remaining_reg     <= remaining_reg - 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign perform_write = perform_write_reg;
  assign write_address = write_address_reg;
  assign write_data    = write_data_reg;
  assign frame_error   = frame_error_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted write.
`timescale 1ns/1ps
module tb_uart_frame_decoder;
  localparam int AW = 9;
  localparam int DB = 3;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready = 1'b0;
  logic          rts = 1'b1;
  logic          write_ready = 1'b1;
  logic          perform_write, busy, frame_error;
  logic [AW-1:0] write_address;
  logic [8*DB-1:0] write_data;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int cycle = 0;
  logic [AW-1:0]   exp_addr [$];
  logic [8*DB-1:0] exp_data [$];
  int              acc_cyc [$];
  logic [7:0]      fq [$];
  logic [AW-1:0]   ea;
  logic [8*DB-1:0] ed;

  always #5 clk = ~clk;

  uart_frame_decoder #(.ADDRESS_WIDTH(AW), .DATA_BYTES(DB)) dut (
    .clock_12mhz  (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_data_ready(rx_ready),
    .rts          (rts),
    .write_ready  (write_ready),
    .perform_write(perform_write),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .frame_error  (frame_error)
  );

  always @(posedge clk) cycle = cycle + 1;

  // Monitor: values seen here are exactly what the next rising edge samples.
  always @(negedge clk) begin
    if (frame_error) err_seen = err_seen + 1;
    if (!reset && perform_write && write_ready) begin
      acc_cyc.push_back(cycle);
      checks = checks + 1;
      if (exp_addr.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write addr=%h data=%h required=none", write_address, write_data);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (write_address !== ea || write_data !== ed) begin
          errors = errors + 1;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   write_address, write_data, ea, ed);
        end else begin
          $display("write addr=%h data=%h ok", write_address, write_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [8*DB-1:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Sends fq as one frame; optionally appends the XOR checksum when enabled,
  // and optionally strobes the last byte in the cycle the rts rise is detected.
  task automatic send_frame(input bit add_cs, input bit last_on_rise);
    logic [7:0] tx [$];
    logic [7:0] cs;
    tx = fq;
    cs = 8'd0;
    foreach (tx[i]) cs = cs ^ tx[i];
    if (add_cs && CS_EN) tx.push_back(cs);
    rts = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < tx.size(); i++) begin
      if (last_on_rise && i == tx.size() - 1) begin
        rts = 1'b1;
        tick();
        tick();
      end
      rx_data = tx[i];
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
    end
    if (!last_on_rise) begin
      tick();
      rts = 1'b1;
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_pw();
    int n;
    n = 0;
    @(negedge clk);
    while (!perform_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pw_seen", {31'd0, perform_write}, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int span;
    // Reset values.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_perform_write", {31'd0, perform_write}, 32'd0);
    check("rst_address", 32'(write_address), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    tick();

    // Single SET_LED.
    e0 = err_seen;
    push_exp(9'h02A, 24'hFF8010);
    fq = '{8'h01, 8'h00, 8'h2A, 8'hFF, 8'h80, 8'h10};
    send_frame(1'b1, 1'b0);
    wait_idle("set_led");
    check("set_led_errs", 32'(err_seen - e0), 32'd0);

    // SET_RANGE wrapping through the top of the address space.
    e0 = err_seen;
    acc_cyc.delete();
    push_exp(9'h1FE, 24'h112233);
    push_exp(9'h1FF, 24'h112233);
    push_exp(9'h000, 24'h112233);
    push_exp(9'h001, 24'h112233);
    fq = '{8'h02, 8'h01, 8'hFE, 8'h04, 8'h11, 8'h22, 8'h33};
    send_frame(1'b1, 1'b0);
    wait_idle("range");
    span = (acc_cyc.size() == 4) ? acc_cyc[3] - acc_cyc[0] : -1;
    check("range_count", 32'(acc_cyc.size()), 32'd4);
    check("range_span", 32'(span), 32'd3);
    check("range_errs", 32'(err_seen - e0), 32'd0);

    // Back-pressure: request held stable while write_ready is low.
    write_ready = 1'b0;
    push_exp(9'h0C3, 24'hA1B2C3);
    fq = '{8'h01, 8'h00, 8'hC3, 8'hA1, 8'hB2, 8'hC3};
    send_frame(1'b1, 1'b0);
    wait_pw();
    acc_cyc.delete();
    for (int k = 0; k < 5; k++) begin
      check("stall_pw", {31'd0, perform_write}, 32'd1);
      check("stall_addr", 32'(write_address), 32'h0C3);
      check("stall_data", 32'(write_data), 32'hA1B2C3);
      @(negedge clk);
    end
    tick();
    write_ready = 1'b1;
    wait_idle("stall");
    check("stall_accepts", 32'(acc_cyc.size()), 32'd1);

    // Short frame, unknown command, long frame (long enough to wrap a
    // non-saturating counter back to a legal length), each one error.
    e0 = err_seen;
    fq = '{8'h01, 8'h00, 8'h2A, 8'hFF, 8'h80};
    send_frame(1'b1, 1'b0);
    wait_idle("short");
    check("short_errs", 32'(err_seen - e0), 32'd1);

    e0 = err_seen;
    fq = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b1, 1'b0);
    wait_idle("unknown");
    check("unknown_errs", 32'(err_seen - e0), 32'd1);

    e0 = err_seen;
    fq = '{8'h01, 8'h00, 8'h2A};
    for (int k = 0; k < 19; k++) fq.push_back(8'h5A);
    send_frame(1'b1, 1'b0);
    wait_idle("long");
    check("long_errs", 32'(err_seen - e0), 32'd1);

    // Byte strobed while IDLE is dropped with one error pulse.
    e0 = err_seen;
    rx_data = 8'h55;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (3) tick();
    check("drop_errs", 32'(err_seen - e0), 32'd1);

    // Last byte coincident with the detected rts rise still counts.
    e0 = err_seen;
    push_exp(9'h100, 24'h123456);
    fq = '{8'h01, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56};
    send_frame(1'b1, 1'b1);
    wait_idle("coincident");
    check("coincident_errs", 32'(err_seen - e0), 32'd0);

`ifdef UART_FRAME_CHECKSUM_EN
    // 0x44 is the XOR of 01 00 2A FF 80 10; 0xA5 is a wrong checksum.
    e0 = err_seen;
    push_exp(9'h02A, 24'hFF8010);
    fq = '{8'h01, 8'h00, 8'h2A, 8'hFF, 8'h80, 8'h10, 8'h44};
    send_frame(1'b0, 1'b0);
    wait_idle("cs_good");
    check("cs_good_errs", 32'(err_seen - e0), 32'd0);

    e0 = err_seen;
    fq = '{8'h01, 8'h00, 8'h2A, 8'hFF, 8'h80, 8'h10, 8'hA5};
    send_frame(1'b0, 1'b0);
    wait_idle("cs_bad");
    check("cs_bad_errs", 32'(err_seen - e0), 32'd1);
`endif

    check("queue_empty", 32'(exp_addr.size()), 32'd0);

    // Reset in the middle of a 256-write burst.
    for (int k = 0; k < 256; k++) push_exp(AW'(9'h010 + k), 24'hAABBCC);
    fq = '{8'h02, 8'h00, 8'h10, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_frame(1'b1, 1'b0);
    wait_pw();
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("reset_pw", {31'd0, perform_write}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) tick();
    reset = 1'b0;
    acc_cyc.delete();
    repeat (40) tick();
    check("post_reset_writes", 32'(acc_cyc.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
